// File: rtl/push_clk_sel_ctrl_if.sv
// rtl/push_clk_sel_ctrl_if.sv - event inputs and display-mux select outputs of push_clk_sel_ctrl
interface push_clk_sel_ctrl_if;
  logic       push_evt;
  logic       blank_btn;
  logic       tick;
  logic       rw1;
  logic       rw0;
  logic       en;
  logic [1:0] view;
  logic [7:0] hold_rem;

  modport master (
    output push_evt, blank_btn, tick,
    input  rw1, rw0, en, view, hold_rem
  );

  modport slave (
    input  push_evt, blank_btn, tick,
    output rw1, rw0, en, view, hold_rem
  );
endinterface

// File: rtl/push_clk_sel_ctrl.sv
// rtl/push_clk_sel_ctrl.sv - display-mux select FSM: clock view, blanking, timed push-count view
module push_clk_sel_ctrl #(
  parameter int HOLD_TICKS = 8
) (
  input logic              clk,
  input logic              rst_n,
  push_clk_sel_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    GAP   = 2'b00,
    CLK   = 2'b01,
    PUSH  = 2'b10,
    BLANK = 2'b11
  } state_t;

  localparam logic [7:0] HOLD_LOAD = (HOLD_TICKS == 0) ? 8'd1 : 8'(HOLD_TICKS);

  state_t     state, state_nxt;
  state_t     tgt, tgt_nxt;
  logic       ret_blank, ret_blank_nxt;
  logic [7:0] hold_cnt, hold_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= GAP;
      tgt          <= CLK;
      ret_blank    <= 1'b0;
      hold_cnt     <= 8'd0;
      bus.rw1      <= 1'b0;
      bus.rw0      <= 1'b0;
      bus.en       <= 1'b0;
      bus.view     <= 2'b00;
      bus.hold_rem <= 8'd0;
    end else begin
      state        <= state_nxt;
      tgt          <= tgt_nxt;
      ret_blank    <= ret_blank_nxt;
      hold_cnt     <= hold_nxt;
      // Outputs are registered from the next state so they line up with it.
      bus.rw1      <= (state_nxt == PUSH);
      bus.rw0      <= (state_nxt == CLK) || (state_nxt == BLANK);
      bus.en       <= (state_nxt == CLK);
      bus.view     <= state_nxt;
      bus.hold_rem <= (state_nxt == PUSH) ? hold_nxt : 8'd0;
    end
  end

  always_comb begin
    state_nxt     = state;
    tgt_nxt       = tgt;
    ret_blank_nxt = ret_blank;
    hold_nxt      = hold_cnt;
    case (state)
      CLK: begin
        if (bus.push_evt) begin
          state_nxt     = GAP;
          tgt_nxt       = PUSH;
          ret_blank_nxt = 1'b0;
        end else if (bus.blank_btn) begin
          state_nxt = BLANK;
        end
      end
      BLANK: begin
        if (bus.push_evt) begin
          state_nxt     = GAP;
          tgt_nxt       = PUSH;
          ret_blank_nxt = 1'b1;
        end else if (bus.blank_btn) begin
          state_nxt = CLK;
        end
      end
      PUSH: begin
        if (bus.blank_btn) ret_blank_nxt = ~ret_blank;
        if (bus.push_evt) begin
          hold_nxt = HOLD_LOAD;
        end else if (bus.tick) begin
          if (hold_cnt > 8'd1) begin
            hold_nxt = hold_cnt - 8'd1;
          end else begin
            // Expiry honours a blank toggle arriving on the same cycle.
            state_nxt = GAP;
            tgt_nxt   = ret_blank_nxt ? BLANK : CLK;
            hold_nxt  = 8'd0;
          end
        end
      end
      GAP: begin
        if (bus.blank_btn) ret_blank_nxt = ~ret_blank;
        if (bus.push_evt) begin
          tgt_nxt = PUSH;
        end else if (bus.blank_btn && (tgt != PUSH)) begin
          tgt_nxt = ret_blank_nxt ? BLANK : CLK;
        end
        state_nxt = tgt_nxt;
        hold_nxt  = (tgt_nxt == PUSH) ? HOLD_LOAD : 8'd0;
      end
      default: state_nxt = GAP;
    endcase
  end

endmodule

// File: tb/tb_push_clk_sel_ctrl.sv
// tb/tb_push_clk_sel_ctrl.sv - randomized check of push_clk_sel_ctrl against a behavioural model
module tb_push_clk_sel_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  push_clk_sel_ctrl_if bus_a ();
  push_clk_sel_ctrl_if bus_b ();

  push_clk_sel_ctrl #(.HOLD_TICKS(3)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  push_clk_sel_ctrl #(.HOLD_TICKS(0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Model views: 0 gap, 1 clock, 2 push, 3 blank.
  int hold_param [2] = '{3, 0};
  int m_view     [2];
  int m_after    [2];
  int m_back_blank [2];
  int m_left     [2];

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_step(int k, bit p, bit b, bit t, bit r);
    int full;
    int home;
    full = (hold_param[k] < 1) ? 1 : hold_param[k];
    if (!r) begin
      m_view[k] = 0; m_after[k] = 1; m_back_blank[k] = 0; m_left[k] = 0;
      return;
    end
    if (m_view[k] == 1 || m_view[k] == 3) begin
      if (p) begin
        m_back_blank[k] = (m_view[k] == 3) ? 1 : 0;
        m_after[k] = 2;
        m_view[k]  = 0;
      end else if (b) begin
        m_view[k] = 4 - m_view[k];
      end
    end else if (m_view[k] == 2) begin
      if (b) m_back_blank[k] = 1 - m_back_blank[k];
      home = m_back_blank[k] ? 3 : 1;
      if (p) m_left[k] = full;
      else if (t && m_left[k] > 1) m_left[k] = m_left[k] - 1;
      else if (t) begin
        m_left[k] = 0; m_after[k] = home; m_view[k] = 0;
      end
    end else begin
      if (b) m_back_blank[k] = 1 - m_back_blank[k];
      home = m_back_blank[k] ? 3 : 1;
      if (p) m_after[k] = 2;
      else if (b && m_after[k] != 2) m_after[k] = home;
      m_view[k] = m_after[k];
      m_left[k] = (m_view[k] == 2) ? full : 0;
    end
  endtask

  task automatic compare_dut(string nm, int k, logic rw1, logic rw0, logic en,
                             logic [1:0] view, logic [7:0] hold_rem);
    check({nm, "_view"}, 32'(view), 32'(m_view[k]));
    check({nm, "_rw1"}, 32'(rw1), 32'(m_view[k] == 2));
    check({nm, "_rw0"}, 32'(rw0), 32'(m_view[k] == 1 || m_view[k] == 3));
    check({nm, "_en"}, 32'(en), 32'(m_view[k] == 1));
    check({nm, "_hold_rem"}, 32'(hold_rem), (m_view[k] == 2) ? 32'(m_left[k]) : 32'd0);
    check({nm, "_excl"}, 32'(rw1 & rw0), 32'd0);
  endtask

  task automatic cycle(bit p, bit b, bit t, bit r);
    bus_a.push_evt = p; bus_a.blank_btn = b; bus_a.tick = t;
    bus_b.push_evt = p; bus_b.blank_btn = b; bus_b.tick = t;
    rst_n = r;
    @(posedge clk);
    cyc++;
    model_step(0, p, b, t, r);
    model_step(1, p, b, t, r);
    #1;
    compare_dut("a", 0, bus_a.rw1, bus_a.rw0, bus_a.en, bus_a.view, bus_a.hold_rem);
    compare_dut("b", 1, bus_b.rw1, bus_b.rw0, bus_b.en, bus_b.view, bus_b.hold_rem);
  endtask

  initial begin
    rst_n = 1'b0;
    bus_a.push_evt = 0; bus_a.blank_btn = 0; bus_a.tick = 0;
    bus_b.push_evt = 0; bus_b.blank_btn = 0; bus_b.tick = 0;

    // Reset, then first idle edge enters the clock view.
    cycle(0, 0, 0, 0);
    check("rst_view", 32'(bus_a.view), 32'd0);
    check("rst_rw0", 32'(bus_a.rw0), 32'd0);
    cycle(0, 0, 0, 1);
    check("idle_view", 32'(bus_a.view), 32'd1);
    check("idle_en", 32'(bus_a.en), 32'd1);

    // Push from clock view; HOLD_TICKS=3 on a, 0 (acts as 1) on b.
    cycle(1, 0, 0, 1);
    check("push_gap", 32'(bus_a.view), 32'd0);
    cycle(0, 0, 0, 1);
    check("push_hold3", 32'(bus_a.hold_rem), 32'd3);
    check("push_hold_b", 32'(bus_b.hold_rem), 32'd1);
    cycle(0, 0, 1, 1);
    check("tick_hold2", 32'(bus_a.hold_rem), 32'd2);
    check("b_expire_gap", 32'(bus_b.view), 32'd0);
    cycle(0, 0, 1, 1);
    check("tick_hold1", 32'(bus_a.hold_rem), 32'd1);
    check("b_back_clk", 32'(bus_b.view), 32'd1);
    cycle(0, 0, 1, 1);
    check("expire_gap", 32'(bus_a.view), 32'd0);
    cycle(0, 0, 0, 1);
    check("back_clk", 32'(bus_a.view), 32'd1);

    // Retrigger at hold 1 with a simultaneous tick.
    cycle(1, 0, 0, 1);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 1, 1);
    cycle(0, 0, 1, 1);
    check("pre_retrig", 32'(bus_a.hold_rem), 32'd1);
    cycle(1, 0, 1, 1);
    check("retrig_view", 32'(bus_a.view), 32'd2);
    check("retrig_hold", 32'(bus_a.hold_rem), 32'd3);
    repeat (3) cycle(0, 0, 1, 1);
    cycle(0, 0, 0, 1);
    check("retrig_clk", 32'(bus_a.view), 32'd1);

    // Blank, push from blank, return to blank.
    cycle(0, 1, 0, 1);
    check("blank_view", 32'(bus_a.view), 32'd3);
    check("blank_en", 32'(bus_a.en), 32'd0);
    cycle(1, 0, 0, 1);
    check("blank_push_gap", 32'(bus_a.view), 32'd0);
    cycle(0, 0, 0, 1);
    check("blank_push", 32'(bus_a.view), 32'd2);
    repeat (3) cycle(0, 0, 1, 1);
    cycle(0, 0, 0, 1);
    check("return_blank", 32'(bus_a.view), 32'd3);

    // Reset in the middle of the push view.
    cycle(1, 0, 0, 1);
    cycle(0, 0, 0, 1);
    cycle(1, 1, 1, 0);
    check("midrst_view", 32'(bus_a.view), 32'd0);
    check("midrst_hold", 32'(bus_a.hold_rem), 32'd0);
    cycle(0, 0, 0, 1);
    cycle(1, 0, 0, 1);
    cycle(0, 0, 0, 1);
    repeat (3) cycle(0, 0, 1, 1);
    cycle(0, 0, 0, 1);
    check("midrst_ret_clk", 32'(bus_a.view), 32'd1);

    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 249) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
